rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
//
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 4:1 datapath mux.
//   - Four requesters compete for one downstream valid/ready channel.
//   - The block picks an owner, drives the mux select and meters bursts of
//     up to MAX_HOLD beats per grant.
//   - On release or hold expiry, ownership rotates fairly.
//   - Sits between the requester lanes and the single consumer.
//
// PARAMETERS
//   WIDTH     8   data bits per lane
//   MAX_HOLD  4   max accepted beats per grant before forced rotation (>=1)
//
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   req        in   4          per-lane request; lane holds req+data until gnt
//   in_data    in   4*WIDTH    lane k = in_data[k*WIDTH +: WIDTH]
//   out_ready  in   1          consumer ready
//   out_valid  out  1          beat valid on output
//   out_data   out  WIDTH      selected lane data
//   sel        out  2          current mux select / owner index
//   gnt        out  4          one-hot, pulses on the cycle a beat from lane k is accepted
//
// BEHAVIOUR
// - Reset (async, rst_n=0):
//     state=IDLE, sel=0, ptr=0, cnt=0, out_valid=0, gnt=0.
//     out_data follows lane 0.
// - FSM IDLE:
//     If |req, pick the first set req at or after ptr (wrapping 3->0).
//     Register sel=pick and cnt=0; go to OWN.
//     Else stay IDLE.
//     IDLE always drives out_valid=0: one bubble cycle per arbitration.
// - FSM OWN:
//     out_valid = req[sel] (combinational).
//     gnt[sel] = out_valid & out_ready; other gnt bits are 0.
//     On accept, cnt+=1.
//     Exit to IDLE, with ptr=(sel+1) mod 4, when either:
//       - the accept makes cnt==MAX_HOLD, or
//       - req[sel]==0 (owner released; no beat that cycle).
// - Backpressure: with out_ready=0, out_valid stays 1 while req[sel]=1.
//     out_data is unchanged (requester holds it), cnt and sel are frozen,
//     and no rotation occurs.
// - Datapath: out_data = in_data lane[sel], combinational from registered sel.
//     Latency req->first beat = 1 cycle (the IDLE cycle). Throughput inside a burst = 1 beat/clk.
// - Fairness: a lane continuously requesting waits at most 3 grants of <=MAX_HOLD beats, each followed by one bubble.
// - Simultaneous events:
//     - New requests during OWN are ignored until IDLE.
//     - Owner dropping req on the same cycle the count would expire: release wins (no beat).
// - Width rule: cnt is $clog2(MAX_HOLD+1) bits. It never exceeds MAX_HOLD.
// - Reset mid-burst: outputs return to reset values immediately, with no clock required. No partial gnt.
// - req[k] without data change is legal. Data changing without gnt is a requester protocol error; the output simply follows it.
//
// STRUCTURE
// - Shared package mux_arb_pkg:
//     - NREQ=4, SELW=2.
//     - State localparams ST_IDLE=1'b0, ST_OWN=1'b1.
// - Sub-module rr_pick (combinational): inputs req[3:0], ptr[1:0]; outputs pick[1:0], any.
// - Data mux: generate WIDTH instances of the team 1-bit mux4to1.
//     Bit i gathers {lane3[i], lane2[i], lane1[i], lane0[i]}; select is sel.
// - Registers: state, sel, ptr, cnt. All use async clear on rst_n.
//
// TESTING  (WIDTH=8, MAX_HOLD=4 unless noted)
// 1. Reset: rst_n=0 with req=4'hF -> out_valid=0, gnt=0, sel=0 immediately.
//    After release, the first grant goes to lane 0.
// 2. Single lane: req=4'b0010, out_ready=1.
//    - 1 IDLE cycle, then sel=1 and 4 beats with gnt=4'b0010.
//    - Then 1 bubble, then lane 1 is regranted.
// 3. All lanes: req=4'hF, ready=1 for 25 cycles.
//    - Grant order 0,1,2,3,0, each 4 beats + 1 bubble.
//    - out_data matches the lane tag bytes 8'hA0..8'hA3.
// 4. Backpressure: out_ready=0 for 3 cycles after beat 2 of lane 2.
//    - out_valid=1 and out_data stable; gnt=0.
//    - Then beats 3-4 complete, then rotation to lane 3.
// 5. Release: lane 2 drops req after 2 beats with req[3]=1.
//    - Next cycle IDLE, then sel=3.
//    - Lane 2 is not regranted before lane 3.
// 6. Async reset mid-burst: assert rst_n between clock edges during beat 3.
//    - out_valid/gnt go to 0 and sel to 0 with no clock edge.
//    - After deassertion, arbitration restarts from lane 0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NREQ / SELW : number of requester lanes and the width of a lane index
//   ST_IDLE / ST_OWN : arbiter FSM state encodings
//   arb_regs_t  : the arbiter's state/owner/pointer registers, grouped in one
//                 struct so the FSM state can be probed as a single signal
//   next_idx    : lane index + 1, wrapping 3 -> 0
//   onehot      : lane index -> one-hot lane mask
package mux_arb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  typedef struct packed {
    logic [0:0]      state;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] ptr;
  } arb_regs_t;

  function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] idx);
    return idx + SELW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4to1.sv
// One-bit 4:1 multiplexer.
//   d : the four candidate bits, d[k] belongs to input k
//   s : select
//   y : d[s]
module mux4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : per-lane request mask
//   ptr  : lane with the highest priority this round
//   pick : first lane with req set, searching ptr, ptr+1, ... (wrapping)
//   any  : at least one request is set (pick is meaningless when 0)
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] pick,
  output logic            any
);

  logic [SELW-1:0] idx;

  // Walk the offsets from farthest to nearest so the closest requesting lane
  // after ptr is the last assignment and therefore wins.
  always_comb begin
    pick = ptr;
    idx  = '0;
    any  = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + SELW'(i);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared 4:1 datapath mux.
// Four requester lanes compete for one downstream channel; the owner may
// send up to MAX_HOLD beats per grant before ownership rotates.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-lane request; a lane holds req and its data until gnt
//   in_data   : lane k data at in_data[k*WIDTH +: WIDTH]
//   out_ready : consumer ready
//   out_valid : beat valid on out_data
//   out_data  : data of the lane selected by sel
//   sel       : current mux select / owner index
//   gnt       : one-hot, high on the cycle a beat from that lane is accepted
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high; gnt is exactly that transfer condition routed back to the
// owning lane. While out_ready is low the beat stays presented unchanged and
// nothing (count, owner, pointer) advances.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       sel,
  output logic [NREQ-1:0]       gnt
);

  localparam int CNTW = $clog2(MAX_HOLD + 1);

  arb_regs_t       r;
  logic [CNTW-1:0] cnt;
  logic [SELW-1:0] pick;
  logic            any;
  logic            accept;
  logic [CNTW-1:0] cnt_inc;

  rr_pick u_pick (
    .req  (req),
    .ptr  (r.ptr),
    .pick (pick),
    .any  (any)
  );

  // Outputs decode straight from registered state, so an asynchronous reset
  // clears out_valid/gnt without waiting for a clock.
  always_comb begin
    out_valid = (r.state == ST_OWN) && req[r.sel];
    accept    = out_valid && out_ready;
    gnt       = accept ? onehot(r.sel) : '0;
    cnt_inc   = cnt + CNTW'(1);
  end

  assign sel = r.sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r.state <= ST_IDLE;
      r.sel   <= '0;
      r.ptr   <= '0;
      cnt     <= '0;
    end else begin
      case (r.state)
        ST_IDLE: begin
          if (any) begin
            r.sel   <= pick;
            cnt     <= '0;
            r.state <= ST_OWN;
          end
        end
        ST_OWN: begin
          // A released owner gets no beat this cycle, even if it was one beat
          // short of expiry, so the release check comes first.
          if (!req[r.sel]) begin
            r.state <= ST_IDLE;
            r.ptr   <= next_idx(r.sel);
          end else if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNTW'(MAX_HOLD)) begin
              r.state <= ST_IDLE;
              r.ptr   <= next_idx(r.sel);
            end
          end
        end
        default: r.state <= ST_IDLE;
      endcase
    end
  end

  // Bit-sliced data mux: bit i picks among bit i of the four lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux4to1 u_mux (
      .d ({in_data[3*WIDTH+i], in_data[2*WIDTH+i], in_data[WIDTH+i], in_data[i]}),
      .s (r.sel),
      .y (out_data[i])
    );
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter (WIDTH=8, MAX_HOLD=4). Directed scenarios push the
// expected beats ({sel, gnt, data}) into exp_q; a monitor on the falling edge
// pops and compares one entry per cycle with out_valid high. Cycle-exact
// points (bubbles, owner changes, reset values) are checked inline.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 8;
  localparam int EW    = 2 + 4 + WIDTH;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [4*WIDTH-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       sel;
  logic [3:0]       gnt;

  logic [WIDTH-1:0] lanes [4];
  assign in_data = {lanes[3], lanes[2], lanes[1], lanes[0]};

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers / drivers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue n beats from lane; accepted beats carry the lane's gnt bit, stalled
  // (out_ready low) beats carry gnt=0.
  task automatic push_beats(input int lane, input int n, input bit accepted,
                            input logic [WIDTH-1:0] data);
    logic [3:0] g;
    g = accepted ? (4'b0001 << lane) : 4'b0000;
    for (int i = 0; i < n; i++) exp_q.push_back({2'(lane), g, data});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        act = {sel, gnt, out_data};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat: unexpected beat sel=%0d gnt=%b data=%h, expected none (t=%0t)",
                   sel, gnt, out_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (act === e) n_pass++;
          else $display("FAIL beat: got sel=%0d gnt=%b data=%h, expected sel=%0d gnt=%b data=%h (t=%0t)",
                        act[EW-1 -: 2], act[WIDTH +: 4], act[WIDTH-1:0],
                        e[EW-1 -: 2], e[WIDTH +: 4], e[WIDTH-1:0], $time);
        end
      end else begin
        chk("idle_gnt", 32'(gnt), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req       = 4'hF;
    out_ready = 1'b1;
    lanes[0]  = 8'hA0;
    lanes[1]  = 8'hA1;
    lanes[2]  = 8'hA2;
    lanes[3]  = 8'hA3;
    #1;

    // 1. reset with all lanes requesting
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_sel",   32'(sel),       32'h0);
    chk("rst_data",  32'(out_data),  32'hA0);
    step();
    step();
    chk("rst_hold_valid", 32'(out_valid), 32'h0);

    // 3. all lanes: 0,1,2,3,0 with 4 beats each and a bubble between
    for (int g = 0; g < 5; g++) push_beats(g % 4, 4, 1'b1, 8'hA0 + 8'(g % 4));
    #3 rst_n = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 1)  chk("all_first_sel", 32'(sel), 32'h0);
      if (n == 6)  chk("all_second_sel", 32'(sel), 32'h1);
      if (n % 5 == 0) chk("all_bubble", 32'(out_valid), 32'h0);
      if (n == 25) req = 4'h0;
    end

    // 2. single lane 1: burst, bubble, regrant
    step();
    lanes[1] = 8'h3C;
    req      = 4'b0010;
    push_beats(1, 8, 1'b1, 8'h3C);
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 1 || n == 6) chk("single_sel", 32'(sel), 32'h1);
      if (n == 5 || n == 10) chk("single_bubble", 32'(out_valid), 32'h0);
      if (n == 10) req = 4'h0;
    end

    // 4. backpressure on lane 2 after beat 2, then rotation to lane 3
    step();
    lanes[2] = 8'h96;
    lanes[3] = 8'h69;
    req      = 4'b1100;
    push_beats(2, 2, 1'b1, 8'h96);
    push_beats(2, 3, 1'b0, 8'h96);
    push_beats(2, 2, 1'b1, 8'h96);
    push_beats(3, 4, 1'b1, 8'h69);
    for (int n = 1; n <= 13; n++) begin
      step();
      if (n == 3) out_ready = 1'b0;
      if (n == 6) out_ready = 1'b1;
      if (n == 1) chk("bp_sel", 32'(sel), 32'h2);
      if (n == 8) chk("bp_bubble", 32'(out_valid), 32'h0);
      if (n == 9) chk("bp_rotate_sel", 32'(sel), 32'h3);
      if (n == 13) req = 4'h0;
    end

    // 5. lane 2 releases after 2 beats; lane 3 is served before lane 2 again
    step();
    lanes[2] = 8'h5A;
    lanes[3] = 8'hC3;
    req      = 4'b1100;
    push_beats(2, 2, 1'b1, 8'h5A);
    push_beats(3, 4, 1'b1, 8'hC3);
    push_beats(2, 4, 1'b1, 8'h5A);
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 3) begin
        req = 4'b1000;
        #1;
        chk("rel_no_beat", 32'(out_valid), 32'h0);
      end
      if (n == 4) begin
        chk("rel_idle", 32'(out_valid), 32'h0);
        req = 4'b1100;
      end
      if (n == 5)  chk("rel_next_sel", 32'(sel), 32'h3);
      if (n == 10) chk("rel_back_sel", 32'(sel), 32'h2);
      if (n == 14) begin
        chk("rel_bubble", 32'(out_valid), 32'h0);
        req = 4'h0;
      end
    end

    // 6. asynchronous reset during beat 3 of lane 1
    step();
    lanes[0] = 8'h0F;
    lanes[1] = 8'hF0;
    req      = 4'b0010;
    push_beats(1, 2, 1'b1, 8'hF0);
    step();
    chk("ar_sel_before", 32'(sel), 32'h1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_gnt",   32'(gnt),       32'h0);
    chk("ar_sel",   32'(sel),       32'h0);
    chk("ar_data",  32'(out_data),  32'h0F);
    req = 4'b0011;
    step();
    step();
    chk("ar_hold_valid", 32'(out_valid), 32'h0);
    push_beats(0, 4, 1'b1, 8'h0F);
    push_beats(1, 4, 1'b1, 8'hF0);
    #3 rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 1) chk("ar_restart_sel", 32'(sel), 32'h0);
      if (n == 5) chk("ar_bubble", 32'(out_valid), 32'h0);
      if (n == 6) chk("ar_next_sel", 32'(sel), 32'h1);
      if (n == 10) req = 4'h0;
    end

    step();
    step();
    step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
